// File: rtl/dispatch_ctrl_if.sv
// Decoder / RS / LSB / ROB handshake bundle for dispatch_ctrl.
// slave  : seen from dispatch_ctrl (decoder and occupancy inputs, dispatch outputs).
// master : seen from the environment that drives the decoder side and observes dispatch.
interface dispatch_ctrl_if #(
  parameter int unsigned NICK_W = 5,
  parameter int unsigned NAME_W = 5
);
  logic              iDEC_en;
  logic [NAME_W-1:0] iDEC_rd_regnm;
  logic              iDEC_is_store;
  logic              iDEC_is_mem;
  logic              oDEC_stall;
  logic              iRS_full;
  logic              iLSB_full;
  logic              oRF_en;
  logic              oROB_nick_en;
  logic [NAME_W-1:0] oROB_nick_regnm;
  logic [NICK_W-1:0] oROB_nick;
  logic              iROB_commit;
  logic              oROB_full;
  logic              oROB_empty;
  logic [NICK_W-1:0] oROB_head_nick;

  modport slave (
    input  iDEC_en, iDEC_rd_regnm, iDEC_is_store, iDEC_is_mem, iRS_full, iLSB_full,
           iROB_commit,
    output oDEC_stall, oRF_en, oROB_nick_en, oROB_nick_regnm, oROB_nick, oROB_full,
           oROB_empty, oROB_head_nick
  );

  modport master (
    output iDEC_en, iDEC_rd_regnm, iDEC_is_store, iDEC_is_mem, iRS_full, iLSB_full,
           iROB_commit,
    input  oDEC_stall, oRF_en, oROB_nick_en, oROB_nick_regnm, oROB_nick, oROB_full,
           oROB_empty, oROB_head_nick
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Instruction dispatch sequencer: single-entry holding buffer between the decoder and the
// rename register file / ROB. Allocates ROB nicks (1..ROB_DEPTH, 0 = not renamed) and
// tracks ROB head/tail/count from its own allocations and ROB commits.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (highest priority)
//   rdy  - global enable; all state holds while low
//   clr  - flush (branch mispredict); discards buffer, ROB pointers and pending pulses
//   bus  - decoder, RS/LSB occupancy, RF dispatch and ROB status signals
module dispatch_ctrl #(
  parameter int unsigned ROB_DEPTH = 16,
  parameter int unsigned NICK_W    = 5,
  parameter int unsigned NAME_W    = 5
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 rdy,
  input logic                 clr,
  dispatch_ctrl_if.slave      bus
);

  localparam logic [NICK_W-1:0] Depth   = NICK_W'(ROB_DEPTH);
  localparam logic [NICK_W-1:0] LastIdx = NICK_W'(ROB_DEPTH - 1);

  typedef enum logic [0:0] {StEmpty, StHold} buf_state_e;

  buf_state_e        buf_q, buf_d;
  logic [NAME_W-1:0] rd_q, rd_d;
  logic              store_q, store_d;
  logic              mem_q, mem_d;
  logic [NICK_W-1:0] head_q, head_d;
  logic [NICK_W-1:0] tail_q, tail_d;
  logic [NICK_W-1:0] count_q, count_d;
  logic              rf_en_q, rf_en_d;
  logic              nick_en_q, nick_en_d;
  logic [NAME_W-1:0] regnm_q, regnm_d;
  logic [NICK_W-1:0] nick_q, nick_d;

  logic issue_ok, stall, do_issue, do_commit, do_capture;

  always_comb begin
    issue_ok   = (buf_q == StHold) && (count_q < Depth) &&
                 !(mem_q ? bus.iLSB_full : bus.iRS_full);
    stall      = (buf_q == StHold) && !issue_ok;
    do_issue   = issue_ok && rdy && !clr;
    do_commit  = bus.iROB_commit && (count_q != '0) && rdy && !clr;
    // A slot frees up in the same edge it issues, so capture only waits on stall.
    do_capture = bus.iDEC_en && !stall && rdy && !clr;
  end

  always_comb begin
    buf_d     = buf_q;
    rd_d      = rd_q;
    store_d   = store_q;
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    rf_en_d   = rf_en_q;
    nick_en_d = nick_en_q;
    regnm_d   = regnm_q;
    nick_d    = nick_q;

    if (rdy) begin
      if (clr) begin
        buf_d     = StEmpty;
        head_d    = '0;
        tail_d    = '0;
        count_d   = '0;
        rf_en_d   = 1'b0;
        nick_en_d = 1'b0;
      end else begin
        rf_en_d   = do_issue;
        nick_en_d = do_issue && !store_q && (rd_q != '0);
        if (do_issue) begin
          regnm_d = rd_q;
          nick_d  = tail_q + 1'b1;
          tail_d  = (tail_q == LastIdx) ? '0 : tail_q + 1'b1;
        end
        if (do_commit) begin
          head_d = (head_q == LastIdx) ? '0 : head_q + 1'b1;
        end
        unique case ({do_issue, do_commit})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        if (do_capture) begin
          buf_d   = StHold;
          rd_d    = bus.iDEC_rd_regnm;
          store_d = bus.iDEC_is_store;
          mem_d   = bus.iDEC_is_mem;
        end else if (do_issue) begin
          buf_d = StEmpty;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q     <= StEmpty;
      rd_q      <= '0;
      store_q   <= 1'b0;
      mem_q     <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rf_en_q   <= 1'b0;
      nick_en_q <= 1'b0;
      regnm_q   <= '0;
      nick_q    <= '0;
    end else begin
      buf_q     <= buf_d;
      rd_q      <= rd_d;
      store_q   <= store_d;
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rf_en_q   <= rf_en_d;
      nick_en_q <= nick_en_d;
      regnm_q   <= regnm_d;
      nick_q    <= nick_d;
    end
  end

  assign bus.oDEC_stall      = stall;
  assign bus.oRF_en          = rf_en_q;
  assign bus.oROB_nick_en    = nick_en_q;
  assign bus.oROB_nick_regnm = regnm_q;
  assign bus.oROB_nick       = nick_q;
  assign bus.oROB_full       = (count_q == Depth);
  assign bus.oROB_empty      = (count_q == '0);
  assign bus.oROB_head_nick  = head_q + 1'b1;

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst, rdy, clr;
  bit   started = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  dispatch_ctrl_if #(.NICK_W(5), .NAME_W(5)) bus ();

  dispatch_ctrl #(.ROB_DEPTH(D), .NICK_W(5), .NAME_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: ROB occupancy is allocations minus commits since the last flush; nicks and
  // head position follow from those totals modulo the ROB depth.
  bit m_valid, m_store, m_mem;
  int m_rd;
  int allocs, commits;
  bit m_rf_en, m_nick_en;
  int m_nick, m_regnm;

  function automatic bit model_can_issue();
    return m_valid && ((allocs - commits) < D) &&
           !(m_mem ? bus.iLSB_full : bus.iRS_full);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_store = 0; m_mem = 0; m_rd = 0;
      allocs = 0; commits = 0;
      m_rf_en = 0; m_nick_en = 0; m_nick = 0; m_regnm = 0;
    end else if (rdy) begin
      if (clr) begin
        m_valid = 0; allocs = 0; commits = 0; m_rf_en = 0; m_nick_en = 0;
      end else begin
        bit ok, stall_now, cap, com;
        ok        = model_can_issue();
        stall_now = m_valid && !ok;
        cap       = bus.iDEC_en && !stall_now;
        com       = bus.iROB_commit && (allocs - commits) > 0;
        m_rf_en   = ok;
        m_nick_en = ok && !m_store && m_rd != 0;
        if (ok) begin
          m_nick  = (allocs % D) + 1;
          m_regnm = m_rd;
          allocs++;
        end
        if (com) commits++;
        if (cap) begin
          m_valid = 1; m_rd = bus.iDEC_rd_regnm;
          m_store = bus.iDEC_is_store; m_mem = bus.iDEC_is_mem;
        end else if (ok) begin
          m_valid = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (started) begin
      chk("stall", bus.oDEC_stall, int'(m_valid && !model_can_issue()));
      chk("rf_en", bus.oRF_en, int'(m_rf_en));
      chk("nick_en", bus.oROB_nick_en, int'(m_nick_en));
      if (m_rf_en) begin
        chk("nick", bus.oROB_nick, m_nick);
        chk("nick_regnm", bus.oROB_nick_regnm, m_regnm);
      end
      chk("full", bus.oROB_full, int'((allocs - commits) == D));
      chk("empty", bus.oROB_empty, int'((allocs - commits) == 0));
      chk("head_nick", bus.oROB_head_nick, (commits % D) + 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int rd, input bit st, input bit mem);
    bus.iDEC_en = 1'b1;
    bus.iDEC_rd_regnm = rd[4:0];
    bus.iDEC_is_store = st;
    bus.iDEC_is_mem = mem;
  endtask

  task automatic idle();
    bus.iDEC_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    bus.iDEC_en = 0; bus.iDEC_rd_regnm = 0; bus.iDEC_is_store = 0; bus.iDEC_is_mem = 0;
    bus.iRS_full = 0; bus.iLSB_full = 0; bus.iROB_commit = 0;
    do_reset();
    started = 1'b1;

    // Reset state and commit on an empty ROB.
    chk("rst_empty", bus.oROB_empty, 1);
    chk("rst_head", bus.oROB_head_nick, 1);
    chk("rst_rf_en", bus.oRF_en, 0);
    bus.iROB_commit = 1; tick(); bus.iROB_commit = 0;
    chk("commit_at_zero_head", bus.oROB_head_nick, 1);
    chk("commit_at_zero_empty", bus.oROB_empty, 1);

    // Three back-to-back non-mem instructions.
    present(5, 0, 0); tick();
    present(6, 0, 0); tick();
    chk("first_nick", bus.oROB_nick, 1);
    chk("first_regnm", bus.oROB_nick_regnm, 5);
    chk("first_empty", bus.oROB_empty, 0);
    present(7, 0, 0); tick();
    idle(); tick();
    chk("third_nick", bus.oROB_nick, 3);
    chk("third_regnm", bus.oROB_nick_regnm, 7);
    tick();
    chk("pulse_clears", bus.oRF_en, 0);

    // Fill the ROB; the 17th instruction stalls until a commit, then takes nick 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      present(i + 1, 0, 0); tick();
    end
    idle(); tick();
    chk("fill_full", bus.oROB_full, 1);
    chk("fill_stall", bus.oDEC_stall, 1);
    bus.iROB_commit = 1; tick(); bus.iROB_commit = 0;
    tick();
    chk("wrap_nick", bus.oROB_nick, 1);
    chk("wrap_regnm", bus.oROB_nick_regnm, 17);
    chk("wrap_full", bus.oROB_full, 1);

    // Store and rd=0 dispatch without rename but still consume nicks.
    do_reset();
    present(3, 1, 0); tick();
    present(0, 0, 0); tick();
    chk("store_nick_en", bus.oROB_nick_en, 0);
    idle(); tick();
    chk("x0_nick_en", bus.oROB_nick_en, 0);
    chk("x0_nick", bus.oROB_nick, 2);
    present(9, 0, 0); tick();
    idle(); tick();
    chk("after_nick", bus.oROB_nick, 3);
    chk("after_nick_en", bus.oROB_nick_en, 1);

    // Mem instruction blocked by a full LSB; RS state is irrelevant while it waits.
    bus.iLSB_full = 1;
    present(10, 0, 1); tick();
    present(11, 0, 0);
    bus.iRS_full = 1;
    for (int i = 0; i < 4; i++) begin
      chk("lsb_wait_stall", bus.oDEC_stall, 1);
      tick();
    end
    bus.iLSB_full = 0; bus.iRS_full = 0;
    tick();
    chk("mem_nick", bus.oROB_nick, 4);
    chk("mem_regnm", bus.oROB_nick_regnm, 10);
    idle(); tick();
    chk("behind_regnm", bus.oROB_nick_regnm, 11);

    // Simultaneous issue and commit at count 8.
    present(12, 0, 0); tick();
    present(13, 0, 0); tick();
    present(14, 0, 0); tick();
    present(15, 0, 0); tick();
    idle(); bus.iROB_commit = 1; tick(); bus.iROB_commit = 0;
    chk("simul_nick", bus.oROB_nick, 9);
    chk("simul_head", bus.oROB_head_nick, 2);

    // Flush while holding, count 5, with a new instruction presented.
    bus.iROB_commit = 1; tick(); tick(); tick(); bus.iROB_commit = 0;
    present(16, 0, 0); tick();
    present(17, 0, 0); clr = 1; tick(); clr = 0;
    chk("clr_empty", bus.oROB_empty, 1);
    chk("clr_rf_en", bus.oRF_en, 0);
    chk("clr_head", bus.oROB_head_nick, 1);
    chk("clr_no_capture", bus.oDEC_stall, 0);
    present(18, 0, 0); tick();
    idle(); tick();
    chk("post_clr_nick", bus.oROB_nick, 1);
    chk("post_clr_regnm", bus.oROB_nick_regnm, 18);

    // rdy low freezes everything, including the dispatch pulse.
    present(20, 0, 0); tick();
    present(21, 0, 0); tick();
    idle(); rdy = 0; tick(); tick();
    chk("rdy_hold_rf_en", bus.oRF_en, 1);
    chk("rdy_hold_nick", bus.oROB_nick, 2);
    rdy = 1; tick();
    chk("rdy_resume_nick", bus.oROB_nick, 3);
    tick();

    started = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
